// File: rtl/assoc_pkg.sv
// Shared types and constants for the associative-memory request front-end.
package assoc_pkg;

    localparam int unsigned ASSOC_DATA_W    = 32;
    localparam int unsigned ASSOC_CNT_W     = 16;
    localparam int unsigned ASSOC_TAG_MAX_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } assoc_state_t;

    // Tag is carried at its widest legal size; the top narrows it to TAG_W.
    typedef struct packed {
        logic [ASSOC_DATA_W-1:0]    data;
        logic [ASSOC_TAG_MAX_W-1:0] tag;
        logic                       err;
    } assoc_rsp_t;

endpackage

// File: rtl/assoc_design.sv
// Small sparse key/value store with registered read data; unwritten keys read as 0.
module assoc_design #(
    parameter int unsigned DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    output logic [31:0] dout
);

    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] valid_q;
    logic [31:0]      key_q [DEPTH];
    logic [31:0]      val_q [DEPTH];
    logic             hit;
    logic [IW-1:0]    hit_idx;
    logic             free;
    logic [IW-1:0]    free_idx;

    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        free     = 1'b0;
        free_idx = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (key_q[i] == addr) && !hit) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
            if (!valid_q[i] && !free) begin
                free     = 1'b1;
                free_idx = IW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dout    <= '0;
        end else begin
            if (we && !hit && free) begin
                valid_q[free_idx] <= 1'b1;
            end
            dout <= hit ? val_q[hit_idx] : '0;
        end
    end

    // A write to a full table with a new key is dropped.
    always_ff @(posedge clk) begin
        if (we) begin
            if (hit) begin
                val_q[hit_idx] <= din;
            end else if (free) begin
                key_q[free_idx] <= addr;
                val_q[free_idx] <= din;
            end
        end
    end

endmodule

// File: rtl/assoc_sat_cnt.sv
// Saturating up-counter with increment enable; sticks at all-ones.
module assoc_sat_cnt
    import assoc_pkg::*;
#(
    parameter int unsigned W = ASSOC_CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/assoc_req_ctrl.sv
// Valid/ready request front-end sequencing one access at a time into assoc_design.
// Optional address range check: define ASSOC_REQ_CTRL_RANGE_CHECK_EN.
module assoc_req_ctrl
    import assoc_pkg::*;
#(
    parameter int TAG_W      = 4,
    parameter int ADDR_LIMIT = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic signed [31:0]      req_addr,
    input  logic [ASSOC_DATA_W-1:0] req_data,
    input  logic [TAG_W-1:0]        req_tag,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ASSOC_DATA_W-1:0] rsp_data,
    output logic [TAG_W-1:0]        rsp_tag,
    output logic                    rsp_err,
    output logic                    mem_we,
    output logic [31:0]             mem_addr,
    output logic [ASSOC_DATA_W-1:0] mem_din,
    input  logic [ASSOC_DATA_W-1:0] mem_dout,
    output logic [ASSOC_CNT_W-1:0]  wr_cnt,
    output logic [ASSOC_CNT_W-1:0]  rd_cnt
);

    if (TAG_W < 1 || TAG_W > int'(ASSOC_TAG_MAX_W) || ADDR_LIMIT <= 0) begin : g_param_err
        $error("assoc_req_ctrl: TAG_W or ADDR_LIMIT out of range");
    end

    assoc_state_t            state_q,     state_d;
    logic                    req_ready_q, req_ready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    assoc_rsp_t              rsp_q,       rsp_d;
    logic                    mem_we_q,    mem_we_d;
    logic [31:0]             mem_addr_q,  mem_addr_d;
    logic [ASSOC_DATA_W-1:0] mem_din_q,   mem_din_d;
    logic                    write_q,     write_d;

    logic accept;
    logic rsp_hs;
    logic addr_bad;
    logic wr_inc;
    logic rd_inc;

    assign accept = req_valid && req_ready_q;
    assign rsp_hs = rsp_valid_q && rsp_ready;

`ifdef ASSOC_REQ_CTRL_RANGE_CHECK_EN
    assign addr_bad = (req_addr < 0) || (req_addr >= ADDR_LIMIT);
`else
    assign addr_bad = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        req_ready_d = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_d       = rsp_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        write_d     = write_q;

        case (state_q)
            ST_IDLE: begin
                req_ready_d = !accept;
                if (accept) begin
                    write_d   = req_write;
                    rsp_d.tag = ASSOC_TAG_MAX_W'(req_tag);
                    rsp_d.data = '0;
                    rsp_d.err = addr_bad;
                    // Rejected addresses bypass the memory and leave its bus untouched.
                    if (addr_bad) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                    end else begin
                        mem_addr_d = req_addr;
                        mem_din_d  = req_data;
                        if (req_write) begin
                            state_d  = ST_WRITE;
                            mem_we_d = 1'b1;
                        end else begin
                            state_d = ST_READ;
                        end
                    end
                end
            end
            ST_WRITE: begin
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
            end
            ST_READ: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                rsp_d.data  = mem_dout;
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
            end
            ST_RESP: begin
                if (rsp_hs) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            write_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_q       <= rsp_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            write_q     <= write_d;
        end
    end

    assign wr_inc = (state_q == ST_RESP) && rsp_hs && write_q  && !rsp_q.err;
    assign rd_inc = (state_q == ST_RESP) && rsp_hs && !write_q && !rsp_q.err;

    assoc_sat_cnt #(.W(ASSOC_CNT_W)) u_wr_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (wr_inc),
        .cnt_o (wr_cnt)
    );

    assoc_sat_cnt #(.W(ASSOC_CNT_W)) u_rd_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (rd_inc),
        .cnt_o (rd_cnt)
    );

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_q.data;
    assign rsp_tag   = TAG_W'(rsp_q.tag);
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_din   = mem_din_q;

`ifdef ASSOC_REQ_CTRL_RANGE_CHECK_EN
    assign rsp_err = rsp_q.err;
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_assoc_req_ctrl.sv
// Directed bench for assoc_req_ctrl driving assoc_design; honours ASSOC_REQ_CTRL_RANGE_CHECK_EN.
module tb_assoc_req_ctrl;

    logic               clk       = 1'b0;
    logic               rst_n     = 1'b1;
    logic               mem_rst_n = 1'b1;
    logic               req_valid = 1'b0;
    logic               req_ready;
    logic               req_write = 1'b0;
    logic signed [31:0] req_addr  = '0;
    logic [31:0]        req_data  = '0;
    logic [3:0]         req_tag   = '0;
    logic               rsp_valid;
    logic               rsp_ready = 1'b1;
    logic [31:0]        rsp_data;
    logic [3:0]         rsp_tag;
    logic               rsp_err;
    logic               mem_we;
    logic [31:0]        mem_addr;
    logic [31:0]        mem_din;
    logic [31:0]        mem_dout;
    logic [15:0]        wr_cnt;
    logic [15:0]        rd_cnt;

    int          total = 0;
    int          bad   = 0;
    int unsigned cyc   = 0;
    int unsigned acc_cyc = 0;
    int          we_cycles = 0;
    int          hs_count  = 0;

    assoc_req_ctrl #(.TAG_W(4), .ADDR_LIMIT(1024)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_tag   (req_tag),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_tag   (rsp_tag),
        .rsp_err   (rsp_err),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout),
        .wr_cnt    (wr_cnt),
        .rd_cnt    (rd_cnt)
    );

    assoc_design #(.DEPTH(8)) u_mem (
        .clk   (clk),
        .rst_n (mem_rst_n),
        .we    (mem_we),
        .addr  (mem_addr),
        .din   (mem_din),
        .dout  (mem_dout)
    );

    always #5 clk = ~clk;

    // Edge monitors see pre-edge values, i.e. what the cycle actually presented.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_we) we_cycles <= we_cycles + 1;
        if (rsp_valid && rsp_ready) hs_count <= hs_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic send(input logic w, input logic signed [31:0] a, input logic [31:0] d,
                        input logic [3:0] t);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("accept_timeout", 32'(req_ready), 32'd1);
        acc_cyc   = cyc;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_data  = d;
        req_tag   = t;
        @(negedge clk);
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        req_tag   = '0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic xact(input logic w, input logic signed [31:0] a, input logic [31:0] d,
                        input logic [3:0] t, input int exp_lat, input logic [31:0] exp_data,
                        input logic exp_err, input string name);
        int lat;
        send(w, a, d, t);
        wait_rsp(lat);
        check({name, "_lat"},  32'(lat),     32'(exp_lat));
        check({name, "_data"}, rsp_data,     exp_data);
        check({name, "_tag"},  32'(rsp_tag), 32'(t));
        check({name, "_err"},  32'(rsp_err), 32'(exp_err));
    endtask

    initial begin
        int lat;
        int we0;
        int hs0;
        int unsigned a0;

        #2;
        rst_n     = 1'b0;
        mem_rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data",  rsp_data,       32'd0);
        check("rst_rsp_tag",   32'(rsp_tag),   32'd0);
        check("rst_rsp_err",   32'(rsp_err),   32'd0);
        check("rst_mem_we",    32'(mem_we),    32'd0);
        check("rst_mem_addr",  mem_addr,       32'd0);
        check("rst_mem_din",   mem_din,        32'd0);
        check("rst_wr_cnt",    32'(wr_cnt),    32'd0);
        check("rst_rd_cnt",    32'(rd_cnt),    32'd0);
        rst_n     = 1'b1;
        mem_rst_n = 1'b1;
        #1 check("rdy_before_edge", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("rdy_after_edge", 32'(req_ready), 32'd1);

        // write then read of the same key
        we0 = we_cycles;
        xact(1'b1, 5, 32'h1234, 4'd3, 2, 32'd0, 1'b0, "wr5");
        @(negedge clk);
        check("wr5_we_cycles",  32'(we_cycles - we0), 32'd1);
        check("wr5_mem_addr",   mem_addr,             32'd5);
        check("wr5_mem_din",    mem_din,              32'h1234);
        check("wr5_mem_we_low", 32'(mem_we),          32'd0);
        check("wr5_valid_clr",  32'(rsp_valid),       32'd0);
        check("wr5_ready_set",  32'(req_ready),       32'd1);
        check("wr5_wr_cnt",     32'(wr_cnt),          32'd1);
        check("wr5_rd_cnt",     32'(rd_cnt),          32'd0);
        xact(1'b0, 5, 32'd0, 4'd9, 3, 32'h1234, 1'b0, "rd5");
        @(negedge clk);
        check("rd5_rd_cnt", 32'(rd_cnt), 32'd1);
        check("rd5_wr_cnt", 32'(wr_cnt), 32'd1);

        xact(1'b0, 77, 32'd0, 4'd2, 3, 32'd0, 1'b0, "rd77");
        @(negedge clk);
        check("rd77_rd_cnt", 32'(rd_cnt), 32'd2);

        // back-pressure
        rsp_ready = 1'b0;
        hs0 = hs_count;
        xact(1'b0, 5, 32'd0, 4'd6, 3, 32'h1234, 1'b0, "bp");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_data",  rsp_data,       32'h1234);
            check("bp_tag",   32'(rsp_tag),   32'd6);
            check("bp_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_valid_clr", 32'(rsp_valid), 32'd0);
        check("bp_ready_set", 32'(req_ready), 32'd1);
        @(negedge clk);
        check("bp_one_rsp", 32'(hs_count - hs0), 32'd1);
        check("bp_rd_cnt",  32'(rd_cnt),         32'd3);

        // back-to-back read-after-write and minimum accept spacing
        send(1'b1, 9, 32'hBEEF, 4'd4);
        a0 = acc_cyc;
        wait_rsp(lat);
        check("b2b_wr_lat", 32'(lat), 32'd2);
        send(1'b0, 9, 32'd0, 4'd5);
        check("b2b_spacing", acc_cyc - a0, 32'd3);
        wait_rsp(lat);
        check("b2b_rd_lat",  32'(lat),     32'd3);
        check("b2b_rd_data", rsp_data,     32'hBEEF);
        check("b2b_rd_tag",  32'(rsp_tag), 32'd5);
        @(negedge clk);

        // reset while the read sits in WAIT
        hs0 = hs_count;
        send(1'b0, 5, 32'd0, 4'd1);
        @(negedge clk);
        check("mid_pre_valid", 32'(rsp_valid), 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_req_ready", 32'(req_ready), 32'd0);
        check("mid_mem_we",    32'(mem_we),    32'd0);
        check("mid_mem_addr",  mem_addr,       32'd0);
        check("mid_rsp_data",  rsp_data,       32'd0);
        check("mid_rsp_tag",   32'(rsp_tag),   32'd0);
        check("mid_wr_cnt",    32'(wr_cnt),    32'd0);
        check("mid_rd_cnt",    32'(rd_cnt),    32'd0);
        repeat (3) @(negedge clk);
        check("mid_hold_valid", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;
        #1 check("mid_rdy_before_edge", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("mid_rdy_after_edge", 32'(req_ready), 32'd1);
        check("mid_no_rsp",         32'(hs_count - hs0), 32'd0);
        check("mid_valid_after",    32'(rsp_valid), 32'd0);

        // address range
        we0 = we_cycles;
`ifdef ASSOC_REQ_CTRL_RANGE_CHECK_EN
        xact(1'b0, 2000, 32'd0, 4'd5, 1, 32'd0, 1'b1, "range2000");
        xact(1'b1, 1024, 32'h55, 4'd7, 1, 32'd0, 1'b1, "range1024");
        xact(1'b1, -3, 32'h66, 4'd8, 1, 32'd0, 1'b1, "range_neg");
        @(negedge clk);
        check("range_no_we",  32'(we_cycles - we0), 32'd0);
        check("range_wr_cnt", 32'(wr_cnt),          32'd0);
        check("range_rd_cnt", 32'(rd_cnt),          32'd0);
        xact(1'b1, 1023, 32'h77, 4'd2, 2, 32'd0, 1'b0, "range1023");
        @(negedge clk);
        check("range_in_we",   32'(we_cycles - we0), 32'd1);
        check("range_in_wcnt", 32'(wr_cnt),          32'd1);
`else
        xact(1'b0, 2000, 32'd0, 4'd5, 3, 32'd0, 1'b0, "range2000");
        @(negedge clk);
        check("range_no_we",  32'(we_cycles - we0), 32'd0);
        check("range_rd_cnt", 32'(rd_cnt),          32'd1);
`endif

        // counter saturation
        @(negedge clk);
        force dut.u_wr_cnt.cnt_q = 16'hFFFE;
        #1 release dut.u_wr_cnt.cnt_q;
        check("sat_preset", 32'(wr_cnt), 32'h0000FFFE);
        for (int i = 0; i < 3; i++) begin
            xact(1'b1, 100 + i, 32'(i), 4'(i), 2, 32'd0, 1'b0, "sat_wr");
            @(negedge clk);
            check("sat_wr_cnt", 32'(wr_cnt), 32'h0000FFFF);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "watchdog expired");
    end

endmodule
